// File: rtl/tdc_pkg.sv
// tdc_pkg: FSM states, default widths and a sizing helper for the TDC readout controller
package tdc_pkg;
  typedef enum logic [1:0] {PLLRST, LOCKWAIT, TDCRST, RUN} tdc_state_e;
  localparam int BYTE_W = 8;
  localparam int DEF_BYTES_PER_HIT = 3;
  localparam int DEF_SEQ_W = 8;
  function automatic int max_int(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/tdc_byte_packer.sv
// tdc_byte_packer: assembles FIFO bytes into sequence-tagged hit words behind a valid/ready register
module tdc_byte_packer
  import tdc_pkg::*;
#(
  parameter int BYTES_PER_HIT = DEF_BYTES_PER_HIT,
  parameter int SEQ_W = DEF_SEQ_W
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   flush_all,
  input  logic                                   flush_part,
  input  logic                                   en,
  input  logic                                   fifo_data_available,
  input  logic [BYTE_W-1:0]                      fifo_dout,
  output logic                                   read_fifo,
  input  logic                                   out_ready,
  output logic                                   out_valid,
  output logic [SEQ_W+BYTE_W*BYTES_PER_HIT-1:0]  out_data
);
  localparam int CW = $clog2(BYTES_PER_HIT + 1);
  localparam int WW = BYTE_W * BYTES_PER_HIT;
  localparam logic [CW-1:0] FULL = CW'(BYTES_PER_HIT);
  logic [CW-1:0] count, nxt_cnt;
  logic in_flight, flush, acc, done, load;
  logic [WW-1:0] shreg, nxt_sh;
  logic [SEQ_W-1:0] seq;
  assign flush = flush_all || flush_part;
  assign acc = out_valid && out_ready;
  assign nxt_cnt = count + CW'(in_flight);
  assign done = nxt_cnt == FULL;
  // the completing byte goes straight to the output register, so a read may overlap the load
  assign load = done && (!out_valid || out_ready) && !flush;
  assign read_fifo = en && fifo_data_available && (nxt_cnt < FULL || load);
  always_comb begin
    nxt_sh = shreg;
    if (in_flight) nxt_sh[BYTE_W*(BYTES_PER_HIT-1-int'(count)) +: BYTE_W] = fifo_dout;
  end
  always_ff @(posedge clk)
    if (rst) begin
      count <= '0;
      in_flight <= 1'b0;
      shreg <= '0;
      seq <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
    end else begin
      if (acc) seq <= seq + SEQ_W'(1);
      in_flight <= read_fifo && !flush;
      count <= (flush || load) ? '0 : nxt_cnt;
      shreg <= nxt_sh;
      if (load) out_data <= {seq + SEQ_W'(acc), nxt_sh};
      out_valid <= load || (out_valid && !acc && !flush_all);
    end
endmodule

// File: rtl/tdc_readout_ctrl.sv
// tdc_readout_ctrl: sequences PLL/TDC bring-up, then drains the TDC byte FIFO into framed hit words
module tdc_readout_ctrl
  import tdc_pkg::*;
#(
  parameter int BYTES_PER_HIT = DEF_BYTES_PER_HIT,
  parameter int PLL_RST_CYCLES = 16,
  parameter int TDC_RST_CYCLES = 64,
  parameter int SEQ_W = DEF_SEQ_W
) (
  input  logic                                   SYSCLK,
  input  logic                                   RESET,
  input  logic                                   restart,
  input  logic                                   pll_locked,
  input  logic                                   hitskip_cfg,
  output logic                                   resetpll_out,
  output logic                                   tdc_reset_out,
  output logic                                   enableHitskip_out,
  input  logic                                   fifo_data_available,
  output logic                                   read_fifo,
  input  logic [BYTE_W-1:0]                      fifo_dout,
  output logic [SEQ_W+BYTE_W*BYTES_PER_HIT-1:0]  out_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic                                   running
);
  localparam int TW = $clog2(max_int(PLL_RST_CYCLES, TDC_RST_CYCLES) + 1);
  tdc_state_e state;
  logic [TW-1:0] cnt;
  logic lost;
  assign lost = !pll_locked && (state == TDCRST || state == RUN);
  assign enableHitskip_out = running && hitskip_cfg;
  always_ff @(posedge SYSCLK)
    if (RESET || restart) begin
      state <= PLLRST;
      cnt <= '0;
      resetpll_out <= 1'b1;
      tdc_reset_out <= 1'b1;
      running <= 1'b0;
    end else if (lost) begin
      state <= LOCKWAIT;
      cnt <= '0;
      tdc_reset_out <= 1'b1;
      running <= 1'b0;
    end else
      case (state)
        PLLRST:
          if (cnt == TW'(PLL_RST_CYCLES - 1)) begin
            state <= LOCKWAIT;
            cnt <= '0;
            resetpll_out <= 1'b0;
          end else cnt <= cnt + TW'(1);
        LOCKWAIT: if (pll_locked) state <= TDCRST;
        TDCRST:
          if (cnt == TW'(TDC_RST_CYCLES)) begin
            state <= RUN;
            cnt <= '0;
            tdc_reset_out <= 1'b0;
            running <= 1'b1;
          end else cnt <= cnt + TW'(1);
        default: ;
      endcase
  tdc_byte_packer #(.BYTES_PER_HIT(BYTES_PER_HIT), .SEQ_W(SEQ_W)) u_packer (
    .clk(SYSCLK),
    .rst(RESET),
    .flush_all(restart),
    .flush_part(lost),
    .en(running),
    .fifo_data_available(fifo_data_available),
    .fifo_dout(fifo_dout),
    .read_fifo(read_fifo),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data(out_data)
  );
endmodule

// File: doc/tdc_readout_ctrl.md
# tdc_readout_ctrl

Sequences TDC bring-up and drains the TDC byte FIFO into framed hit words. It runs on the TDC system clock next to `timegen`. It drives PLL reset and TDC reset in order, then pops bytes with `read_fifo`/`fifo_dout` and packs `BYTES_PER_HIT` bytes into one hit word. It tags each word with a wrapping sequence number and presents it on a valid/ready stream to the downstream readout link.

## Interface
- `BYTES_PER_HIT`, 3: FIFO bytes per hit word, range 1..8.
- `PLL_RST_CYCLES`, 16: cycles `resetpll_out` is held high.
- `TDC_RST_CYCLES`, 64: cycles `tdc_reset_out` is held high after lock.
- `SEQ_W`, 8: sequence counter width.
- `SYSCLK` in 1: single clock; all logic rising-edge.
- `RESET` in 1: synchronous, active-high reset.
- `restart` in 1: one-cycle pulse; aborts and re-runs the bring-up sequence.
- `pll_locked` in 1: PLL lock indication, already synchronous to `SYSCLK`.
- `hitskip_cfg` in 1: requested hit-skip mode.
- `resetpll_out` out 1: PLL reset.
- `tdc_reset_out` out 1: to `timegen` `RESET`.
- `enableHitskip_out` out 1: equals `hitskip_cfg` in RUN, 0 otherwise.
- `fifo_data_available` in 1: TDC FIFO non-empty.
- `read_fifo` out 1: pop strobe.
- `fifo_dout` in 8: byte popped by the previous cycle's `read_fifo`.
- `out_data` out `SEQ_W+8*BYTES_PER_HIT`: {seq, byte0..byteN-1}, byte0 is in the MSBs.
- `out_valid` out 1 / `out_ready` in 1: output handshake.
- `running` out 1: high in RUN.

## Operation
- FSM states:
  - PLLRST: `resetpll_out`=1, `tdc_reset_out`=1. Counts `PLL_RST_CYCLES`, then goes to LOCKWAIT.
  - LOCKWAIT: `resetpll_out`=0, `tdc_reset_out`=1. Waits for `pll_locked`=1, then goes to TDCRST.
  - TDCRST: `tdc_reset_out`=1. Counts `TDC_RST_CYCLES`, then goes to RUN.
  - RUN: `tdc_reset_out`=0, `running`=1.
- `pll_locked` falling in TDCRST or RUN → LOCKWAIT. This discards the partial word and in-flight byte.
- `restart` in any state → PLLRST, with the same discard and `out_valid` cleared. `restart` has priority over every other event.
- Assembly in RUN:
  - `read_fifo` = `fifo_data_available` && (bytes held + byte in flight < `BYTES_PER_HIT`) && !(word complete && `out_valid`).
  - Each read returns one byte, captured on the following cycle into slot `count`.
  - When the last byte is captured and the output register is free (`!out_valid`, or it is accepted in that same cycle), the word is loaded. `out_valid` then rises on the next cycle.
  - `seq` is stamped at load time. It increments on each accepted handshake (`out_valid`&&`out_ready`) and wraps 2^SEQ_W−1 → 0.
- While a complete word waits for a busy output register, reads stop. Bytes stay in the TDC FIFO; nothing is dropped.
- Leaving RUN other than via `restart`/`RESET`: an `out_valid` word already loaded stays until it is accepted.

## Timing
- Reset values:
  - `resetpll_out`=1, `tdc_reset_out`=1, `read_fifo`=0.
  - `out_valid`=0, `out_data`=0.
  - `running`=0, `enableHitskip_out`=0.
  - seq=0, state PLLRST.
- `resetpll_out` stays high for exactly `PLL_RST_CYCLES` cycles after `RESET` deasserts.
- Once `pll_locked` is high, `tdc_reset_out` stays high for `TDC_RST_CYCLES`+1 cycles.
- Fifo latency is 1 cycle, read strobe → `fifo_dout` capture. Reads can issue back-to-back.
- Latency from the first `read_fifo` to `out_valid` is `BYTES_PER_HIT`+1 cycles with a continuously available FIFO.
- Sustained throughput is one word per `BYTES_PER_HIT` cycles with `out_ready`=1.
- Once `out_valid` is high, `out_data` is stable until accepted. Only `restart`/`RESET` may drop it.
- Byte count is `$clog2(BYTES_PER_HIT+1)` bits wide. Its state counter is sized to max(`PLL_RST_CYCLES`,`TDC_RST_CYCLES`).

## Structure
- Package `tdc_pkg`: FSM state enum (PLLRST, LOCKWAIT, TDCRST, RUN) and the default byte/seq widths.
- One sub-module, `tdc_byte_packer`. It holds the byte count, the in-flight flag, the shift register and the output register with valid/ready. The top holds the FSM and the reset timers.

## Test plan
- Reset with `pll_locked`=1 from cycle 0:
  - `resetpll_out` high for 16 cycles.
  - `tdc_reset_out` falls 16+1+65 cycles after reset release.
  - `running` rises in the same cycle as that fall.
- RUN with FIFO bytes 0x11,0x22,0x33,0x44,0x55,0x66 and `out_ready`=1 → two words: 0x00_112233, then 0x01_445566.
- `out_ready`=0 for 20 cycles with 9 bytes queued:
  - Exactly 6 reads happen.
  - Word 0 is held stable.
  - On release, all three words arrive with seq 0,1,2.
- Accept 256 words → the seq of word 256 is 0x00 (wrap).
- `pll_locked` drops after 2 bytes of a word:
  - Partial word discarded; state goes to LOCKWAIT.
  - After relock and TDCRST, the next word is built from fresh bytes only.
- `restart` in the same cycle as a handshake:
  - Word counted as accepted and seq incremented.
  - `out_valid`=0 and `resetpll_out`=1 on the next cycle.
